// File: rtl/data_stack.sv
// Data-stack unit for the 16-bit stack CPU: top of stack in a register,
// deeper entries in a small array indexed by the live-entry depth.
module data_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       load_stk,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           stk0,
  output logic [WIDTH-1:0]           stk1,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       unf
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] stk0_q, stk0_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             mem_we;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic             is_empty, is_full;

  // array[depth-1] receives the old top on a push; stk1 lives at depth-2
  assign wr_idx   = AW'(depth_q - DW'(1));
  assign rd_idx   = AW'(depth_q - DW'(2));
  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == DW'(DEPTH));

  assign stk0  = stk0_q;
  assign stk1  = (depth_q >= DW'(2)) ? mem[rd_idx] : '0;
  assign depth = depth_q;
  assign empty = is_empty;
  assign full  = is_full;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    stk0_d  = stk0_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    mem_we  = 1'b0;

    if (push && pop) begin
      // Net depth unchanged: behaves exactly like a bare load_stk
      if (load_stk) begin
        stk0_d = data_in;
        if (is_empty) depth_d = DW'(1);
      end
    end else if (push) begin
      if (is_full) begin
        ovf_d = 1'b1;
      end else begin
        mem_we  = !is_empty;
        stk0_d  = load_stk ? data_in : (is_empty ? '0 : stk0_q);
        depth_d = depth_q + DW'(1);
      end
    end else if (pop) begin
      if (is_empty) begin
        unf_d = 1'b1;
      end else begin
        stk0_d  = load_stk ? data_in : stk1;
        depth_d = depth_q - DW'(1);
      end
    end else if (load_stk) begin
      stk0_d = data_in;
      if (is_empty) depth_d = DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      stk0_q  <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      stk0_q  <= stk0_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // NOTE: the entry array has no reset; depth alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_idx] <= stk0_q;
  end

endmodule

// File: tb/tb_data_stack.sv
// Directed self-checking bench for data_stack: push/pop/load sequences,
// boundary flags and asynchronous reset.
module tb_data_stack;

  logic        clk = 1'b0;
  logic        rst;
  logic        push, pop, load_stk;
  logic [15:0] data_in;
  logic [15:0] stk0, stk1;
  logic [4:0]  depth;
  logic        empty, full, ovf, unf;

  int passed = 0;
  int total  = 0;

  data_stack #(.WIDTH(16), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .load_stk(load_stk),
    .data_in(data_in), .stk0(stk0), .stk1(stk1), .depth(depth),
    .empty(empty), .full(full), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  // Drive one operation on the falling edge, let it clock, sample 1 ns later
  task automatic step(input logic p, input logic o, input logic l, input logic [15:0] d);
    @(negedge clk);
    push = p; pop = o; load_stk = l; data_in = d;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; load_stk = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; push = 1'b0; pop = 1'b0; load_stk = 1'b0; data_in = '0;
    #1;
    total++; if ({stk0, stk1, depth} !== {16'h0, 16'h0, 5'd0})
      $display("FAIL reset_values stk0=%h stk1=%h depth=%0d want 0/0/0", stk0, stk1, depth);
    else passed++;
    total++; if ({empty, full, ovf, unf} !== 4'b1000)
      $display("FAIL reset_flags e/f/o/u=%b want 1000", {empty, full, ovf, unf});
    else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_push_load;
    step(1, 0, 1, 16'h0BEF);
    step(1, 0, 1, 16'h1234);
    total++; if ({stk0, stk1, depth} !== {16'h1234, 16'h0BEF, 5'd2})
      $display("FAIL push_load stk0=%h stk1=%h depth=%0d want 1234/0bef/2", stk0, stk1, depth);
    else passed++;
  endtask

  task automatic test_binary_op;
    step(0, 1, 1, 16'h0024);
    total++; if ({stk0, stk1, depth} !== {16'h0024, 16'h0, 5'd1})
      $display("FAIL binary_op stk0=%h stk1=%h depth=%0d want 0024/0000/1", stk0, stk1, depth);
    else passed++;
  endtask

  task automatic test_dup_unary;
    step(1, 0, 0, 16'hDEAD);
    total++; if ({stk0, stk1, depth} !== {16'h0024, 16'h0024, 5'd2})
      $display("FAIL dup stk0=%h stk1=%h depth=%0d want 0024/0024/2", stk0, stk1, depth);
    else passed++;
    step(0, 0, 1, 16'h0025);
    total++; if ({stk0, stk1, depth} !== {16'h0025, 16'h0024, 5'd2})
      $display("FAIL unary stk0=%h stk1=%h depth=%0d want 0025/0024/2", stk0, stk1, depth);
    else passed++;
  endtask

  // Drain to empty exercising pop-only, pop+load at depth 1 and dup of an empty stack
  task automatic test_drain;
    step(0, 1, 0, 16'h0);
    total++; if ({stk0, stk1, depth} !== {16'h0024, 16'h0, 5'd1})
      $display("FAIL pop_only stk0=%h stk1=%h depth=%0d want 0024/0000/1", stk0, stk1, depth);
    else passed++;
    step(0, 1, 1, 16'h0055);
    total++; if ({stk0, depth, empty, unf} !== {16'h0055, 5'd0, 1'b1, 1'b0})
      $display("FAIL pop_load_d1 stk0=%h depth=%0d empty=%b unf=%b want 0055/0/1/0", stk0, depth, empty, unf);
    else passed++;
    step(1, 0, 0, 16'hBEEF);
    total++; if ({stk0, stk1, depth} !== {16'h0, 16'h0, 5'd1})
      $display("FAIL dup_empty stk0=%h stk1=%h depth=%0d want 0000/0000/1", stk0, stk1, depth);
    else passed++;
    step(0, 1, 0, 16'h0);
    total++; if ({stk0, depth, empty, unf} !== {16'h0, 5'd0, 1'b1, 1'b0})
      $display("FAIL pop_to_empty stk0=%h depth=%0d empty=%b unf=%b want 0000/0/1/0", stk0, depth, empty, unf);
    else passed++;
  endtask

  task automatic test_ovf_unf;
    for (int i = 1; i <= 16; i++) step(1, 0, 1, 16'(i));
    total++; if ({stk0, stk1, depth, full, ovf} !== {16'd16, 16'd15, 5'd16, 1'b1, 1'b0})
      $display("FAIL fill stk0=%h stk1=%h depth=%0d full=%b ovf=%b want 0010/000f/16/1/0", stk0, stk1, depth, full, ovf);
    else passed++;
    step(1, 0, 1, 16'hFFFF);
    total++; if ({stk0, stk1, depth, full, ovf} !== {16'd16, 16'd15, 5'd16, 1'b1, 1'b1})
      $display("FAIL overflow stk0=%h stk1=%h depth=%0d full=%b ovf=%b want 0010/000f/16/1/1", stk0, stk1, depth, full, ovf);
    else passed++;
    for (int i = 0; i < 8; i++) step(0, 1, 0, 16'h0);
    total++; if ({stk0, stk1, depth} !== {16'd8, 16'd7, 5'd8})
      $display("FAIL half_drain stk0=%h stk1=%h depth=%0d want 0008/0007/8", stk0, stk1, depth);
    else passed++;
    for (int i = 0; i < 8; i++) step(0, 1, 0, 16'h0);
    total++; if ({stk0, depth, empty, unf, ovf} !== {16'h0, 5'd0, 1'b1, 1'b0, 1'b1})
      $display("FAIL drained stk0=%h depth=%0d empty=%b unf=%b ovf=%b want 0000/0/1/0/1", stk0, depth, empty, unf, ovf);
    else passed++;
    step(0, 1, 0, 16'h0);
    total++; if ({stk0, depth, empty, unf, ovf} !== {16'h0, 5'd0, 1'b1, 1'b1, 1'b1})
      $display("FAIL underflow stk0=%h depth=%0d empty=%b unf=%b ovf=%b want 0000/0/1/1/1", stk0, depth, empty, unf, ovf);
    else passed++;
  endtask

  task automatic test_push_pop;
    step(0, 0, 1, 16'h0007);
    total++; if ({stk0, depth} !== {16'h0007, 5'd1})
      $display("FAIL load_empty stk0=%h depth=%0d want 0007/1", stk0, depth);
    else passed++;
    step(1, 0, 1, 16'h0005);
    step(1, 1, 1, 16'h0009);
    total++; if ({stk0, stk1, depth} !== {16'h0009, 16'h0007, 5'd2})
      $display("FAIL push_pop_load stk0=%h stk1=%h depth=%0d want 0009/0007/2", stk0, stk1, depth);
    else passed++;
    step(1, 1, 0, 16'h00AA);
    total++; if ({stk0, stk1, depth} !== {16'h0009, 16'h0007, 5'd2})
      $display("FAIL push_pop_hold stk0=%h stk1=%h depth=%0d want 0009/0007/2", stk0, stk1, depth);
    else passed++;
  endtask

  task automatic test_reset_mid;
    step(1, 0, 1, 16'h0011);
    total++; if (depth !== 5'd3)
      $display("FAIL pre_reset_depth depth=%0d want 3", depth);
    else passed++;
    @(negedge clk); #2 rst = 1'b1; #1;
    total++; if ({stk0, stk1, depth, empty, ovf, unf} !== {16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL async_reset stk0=%h stk1=%h depth=%0d e/o/u=%b want 0000/0000/0/100", stk0, stk1, depth, {empty, ovf, unf});
    else passed++;
    @(negedge clk); rst = 1'b0;
    step(1, 0, 0, 16'h0);
    total++; if ({stk0, stk1, depth} !== {16'h0, 16'h0, 5'd1})
      $display("FAIL post_reset_dup stk0=%h stk1=%h depth=%0d want 0000/0000/1", stk0, stk1, depth);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_push_load();
    test_binary_op();
    test_dup_unary();
    test_drain();
    test_ovf_unf();
    test_push_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
